// File: rtl/mod_counter_checker.sv
// Online monitor for a mod-N counter: predicts each next Q, flags
// sequence and range violations, counts errors and wraps.
module mod_counter_checker #(
    parameter int N        = 10,
    parameter int LOCK_CNT = 2,
    parameter int CW       = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic [$clog2(N)-1:0] q_in,
    input  logic                 resync,
    input  logic                 clear,
    output logic                 locked,
    output logic                 err_pulse,
    output logic                 err_sticky,
    output logic [CW-1:0]        err_count,
    output logic                 wrap_pulse,
    output logic [CW-1:0]        wrap_count
);

    localparam int NW = $clog2(N);

    localparam logic [1:0] ST_ACQ = 2'd0;
    localparam logic [1:0] ST_LCK = 2'd1;
    localparam logic [1:0] ST_FLT = 2'd2;

    localparam logic [NW:0]   N_W   = (NW+1)'(N);
    localparam logic [NW-1:0] NM1   = NW'(N - 1);
    localparam logic [3:0]    LC    = 4'(LOCK_CNT);
    localparam logic [NW:0]   ONE_W = (NW+1)'(1);

    logic [1:0]    state_q, state_d;
    logic [3:0]    mcnt_q, mcnt_d;
    logic          pv_q, pv_d;
    logic [NW-1:0] sq_q, sq_d;
    logic          sen_q, sen_d;
    logic          locked_q, locked_d;
    logic          errp_q, errp_d;
    logic          sticky_q, sticky_d;
    logic [CW-1:0] ecnt_q, ecnt_d;
    logic          wrapp_q, wrapp_d;
    logic [CW-1:0] wcnt_q, wcnt_d;

    logic [NW:0] exp_w;
    logic        range_err;
    logic        match;
    logic [3:0]  mcnt_inc;
    logic        err_ev;
    logic        wrap_ev;

    // Prediction carries an extra bit so the N-1 -> 0 wrap cannot alias
    assign exp_w = !sen_q        ? {1'b0, sq_q} :
                   (sq_q == NM1) ? '0 :
                                   {1'b0, sq_q} + ONE_W;

    assign range_err = {1'b0, q_in} >= N_W;
    assign match     = pv_q && !range_err && ({1'b0, q_in} == exp_w);
    assign mcnt_inc  = mcnt_q + 4'd1;

    always_comb begin
        state_d = state_q;
        mcnt_d  = mcnt_q;
        pv_d    = !range_err;
        sq_d    = q_in;
        sen_d   = en;
        err_ev  = 1'b0;
        wrap_ev = 1'b0;

        unique case (state_q)
            ST_ACQ, ST_FLT: begin
                if (range_err) begin
                    mcnt_d = '0;
                    err_ev = (state_q == ST_FLT);
                end else if (!pv_q) begin
                    mcnt_d = '0;
                end else if (match) begin
                    mcnt_d = mcnt_inc;
                    if (mcnt_inc == LC)
                        state_d = ST_LCK;
                end else begin
                    mcnt_d = '0;
                    err_ev = (state_q == ST_FLT);
                end
            end
            ST_LCK: begin
                if (match) begin
                    wrap_ev = sen_q && (sq_q == NM1);
                end else begin
                    err_ev  = 1'b1;
                    state_d = ST_FLT;
                    mcnt_d  = '0;
                end
            end
            default: begin
                state_d = ST_ACQ;
                mcnt_d  = '0;
                pv_d    = 1'b0;
            end
        endcase

        // Re-acquisition suppresses any error seen on the same edge
        if (resync) begin
            state_d = ST_ACQ;
            mcnt_d  = '0;
            pv_d    = 1'b0;
            err_ev  = 1'b0;
        end

        locked_d = (state_d == ST_LCK);
        errp_d   = err_ev;
        wrapp_d  = wrap_ev;

        if (clear) begin
            ecnt_d   = '0;
            wcnt_d   = '0;
            sticky_d = 1'b0;
        end else begin
            ecnt_d   = (err_ev && ecnt_q != '1) ? ecnt_q + 1'b1 : ecnt_q;
            wcnt_d   = (wrap_ev && wcnt_q != '1) ? wcnt_q + 1'b1 : wcnt_q;
            sticky_d = sticky_q | err_ev;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_ACQ;
            mcnt_q   <= '0;
            pv_q     <= 1'b0;
            sq_q     <= '0;
            sen_q    <= 1'b0;
            locked_q <= 1'b0;
            errp_q   <= 1'b0;
            sticky_q <= 1'b0;
            ecnt_q   <= '0;
            wrapp_q  <= 1'b0;
            wcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            mcnt_q   <= mcnt_d;
            pv_q     <= pv_d;
            sq_q     <= sq_d;
            sen_q    <= sen_d;
            locked_q <= locked_d;
            errp_q   <= errp_d;
            sticky_q <= sticky_d;
            ecnt_q   <= ecnt_d;
            wrapp_q  <= wrapp_d;
            wcnt_q   <= wcnt_d;
        end
    end

    assign locked     = locked_q;
    assign err_pulse  = errp_q;
    assign err_sticky = sticky_q;
    assign err_count  = ecnt_q;
    assign wrap_pulse = wrapp_q;
    assign wrap_count = wcnt_q;

endmodule

// File: tb/tb_mod_counter_checker.sv
// Directed bench for mod_counter_checker (N=10, LOCK_CNT=2, CW=8).
// A bench-side counter value cq supplies the legal Q sequence.
module tb_mod_counter_checker;

    localparam int N = 10;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] q_in = 4'd0;
    logic       resync = 1'b0;
    logic       clear = 1'b0;
    logic       locked;
    logic       err_pulse;
    logic       err_sticky;
    logic [7:0] err_count;
    logic       wrap_pulse;
    logic [7:0] wrap_count;

    int tests = 0;
    int fails = 0;
    int cq = 0;

    mod_counter_checker #(.N(10), .LOCK_CNT(2), .CW(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .q_in       (q_in),
        .resync     (resync),
        .clear      (clear),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .err_count  (err_count),
        .wrap_pulse (wrap_pulse),
        .wrap_count (wrap_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic e, input logic [3:0] q);
        en   = e;
        q_in = q;
        @(posedge clk);
        #1;
    endtask

    task automatic adv(input logic e);
        if (e)
            cq = (cq == N - 1) ? 0 : cq + 1;
    endtask

    task automatic tick(input logic e);
        drive(e, 4'(cq));
        adv(e);
    endtask

    // Counter jumps to an in-range forced value; out-of-range is a bus glitch
    task automatic glitch(input logic e, input logic [3:0] q);
        drive(e, q);
        if (int'(q) < N)
            cq = int'(q);
        adv(e);
    endtask

    initial begin
        #2;
        chk("rst_locked", 32'(locked), 0);
        chk("rst_errp", 32'(err_pulse), 0);
        chk("rst_sticky", 32'(err_sticky), 0);
        chk("rst_ecnt", 32'(err_count), 0);
        chk("rst_wrapp", 32'(wrap_pulse), 0);
        chk("rst_wcnt", 32'(wrap_count), 0);
        #1 reset_n = 1'b1;
        #1;

        for (int k = 1; k <= 13; k++) begin
            tick(1'b1);
            chk($sformatf("run_locked_%0d", k), 32'(locked), 32'(k >= 3));
            chk($sformatf("run_wrapp_%0d", k), 32'(wrap_pulse),
                32'(k == 11));
        end
        chk("run_wcnt", 32'(wrap_count), 1);
        chk("run_ecnt", 32'(err_count), 0);

        tick(1'b1);
        tick(1'b0);
        chk("hold_errp", 32'(err_pulse), 0);
        tick(1'b0);
        chk("hold_locked", 32'(locked), 1);
        tick(1'b1);
        chk("hold_ecnt", 32'(err_count), 0);
        chk("hold_locked2", 32'(locked), 1);

        glitch(1'b1, 4'd6);
        chk("mis_errp", 32'(err_pulse), 1);
        chk("mis_sticky", 32'(err_sticky), 1);
        chk("mis_ecnt", 32'(err_count), 1);
        chk("mis_locked", 32'(locked), 0);
        tick(1'b1);
        chk("mis_errp_off", 32'(err_pulse), 0);
        chk("mis_relock1", 32'(locked), 0);
        tick(1'b1);
        chk("mis_relock2", 32'(locked), 1);
        chk("mis_ecnt2", 32'(err_count), 1);

        glitch(1'b1, 4'd12);
        chk("rng_errp", 32'(err_pulse), 1);
        chk("rng_ecnt", 32'(err_count), 2);
        chk("rng_locked", 32'(locked), 0);
        tick(1'b1);
        chk("rng_load_errp", 32'(err_pulse), 0);
        chk("rng_load_locked", 32'(locked), 0);
        tick(1'b1);
        chk("rng_m1_locked", 32'(locked), 0);
        tick(1'b1);
        chk("rng_relock", 32'(locked), 1);
        chk("rng_ecnt2", 32'(err_count), 2);

        resync = 1'b1;
        glitch(1'b1, 4'd7);
        resync = 1'b0;
        chk("rs_errp", 32'(err_pulse), 0);
        chk("rs_ecnt", 32'(err_count), 2);
        chk("rs_locked", 32'(locked), 0);
        tick(1'b1);
        chk("rs_load", 32'(locked), 0);
        tick(1'b1);
        chk("rs_m1", 32'(locked), 0);
        tick(1'b1);
        chk("rs_relock", 32'(locked), 1);
        chk("rs_nowrap", 32'(wrap_pulse), 0);
        chk("rs_wcnt", 32'(wrap_count), 1);

        for (int i = 0; i < 253; i++) begin
            drive(1'b0, (i % 2 == 1) ? 4'd5 : 4'd3);
            chk("sat_errp", 32'(err_pulse), 1);
        end
        chk("sat_ecnt_255", 32'(err_count), 255);
        drive(1'b0, 4'd5);
        chk("sat_hold", 32'(err_count), 255);
        chk("sat_errp2", 32'(err_pulse), 1);

        clear = 1'b1;
        drive(1'b0, 4'd3);
        clear = 1'b0;
        chk("clr_ecnt", 32'(err_count), 0);
        chk("clr_errp", 32'(err_pulse), 1);
        chk("clr_sticky", 32'(err_sticky), 0);
        chk("clr_wcnt", 32'(wrap_count), 0);
        drive(1'b0, 4'd5);
        chk("post_clr_ecnt", 32'(err_count), 1);
        chk("post_clr_sticky", 32'(err_sticky), 1);

        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_ecnt", 32'(err_count), 0);
        chk("mid_rst_sticky", 32'(err_sticky), 0);
        chk("mid_rst_errp", 32'(err_pulse), 0);
        chk("mid_rst_locked", 32'(locked), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
